instr_mem_responder: RTL and testbench
======================================

# instr_mem_responder

Responder end of the fetch-to-instruction-memory strobe/ack interface. Accepts word-fetch requests from `fetch_unit`, returns the instruction word after a per-request latency (fixed, or pseudo-random from an internal LFSR), and flags misaligned or out-of-range fetches. This replaces ad-hoc testbench ack-delay logic with a synthesizable memory model. Sits between `fetch_unit` (`o_iaddr`/`o_iaddr_vld` → `i_addr`/`i_stb`) and its `i_inst`/`i_inst_vld` inputs.

## Interface
- `DEPTH_WORDS`, 1024: memory size in 32-bit words, power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `MIN_LAT`, 1: minimum response latency in cycles, ≥1.
- `MAX_LAT`, 8: maximum response latency in cycles, ≥`MIN_LAT`, ≤16.
- `RANDOM_LAT`, 1: 1 = LFSR-selected latency, 0 = always `MIN_LAT`.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_addr` input 32: fetch byte address.
- `i_stb` input 1: request strobe, sampled every cycle.
- `o_data` output 32: instruction word, valid only while `o_ack`=1.
- `o_ack` output 1: one-cycle response pulse.
- `o_err` output 1: qualifies `o_ack`; the fetch was misaligned or out of range.
- `o_busy` output 1: a request is in flight.
- `o_overrun` output 1: one-cycle pulse; a strobe was dropped.
- `i_wr_en` input 1: preload write enable.
- `i_wr_addr` input 32: preload byte address, word-aligned.
- `i_wr_data` input 32: preload data.

## Operation
- FSM states: IDLE, WAIT, RESP.
- Request acceptance:
  - Accepted in IDLE when `i_stb`=1, or in RESP when a pending request or `i_stb` is present. Pending takes priority, and the concurrent `i_stb` is then stored as the new pending request.
  - On accept, capture the address and compute latency L. Go to RESP if L=1, else WAIT with down-counter = L-1.
- Latency:
  - `RANDOM_LAT`=1: L = `MIN_LAT` + (lfsr[7:0] mod (`MAX_LAT`-`MIN_LAT`+1)), using the LFSR value in the accept cycle.
  - `RANDOM_LAT`=0: L = `MIN_LAT`.
- LFSR: 16-bit Galois, mask 16'hB400 (shift right; XOR the mask when the LSB is 1). Advances every non-reset cycle, independent of traffic.
- WAIT: decrement the counter each cycle. Go to RESP when the counter reaches 1 at the clock edge.
- RESP: `o_ack`=1 for exactly one cycle. Then either accept a new request (see Request acceptance) or return to IDLE.
- Pending slot (1 entry):
  - A strobe arriving in WAIT, or in RESP without acceptance, is stored if the slot is empty.
  - If the slot is full, the strobe is dropped and `o_overrun` pulses the next cycle.
- Error fetch: `i_addr[1:0]`≠0, or the word index (`i_addr`-`BASE_ADDR`)>>2 ≥ `DEPTH_WORDS`. The request still takes latency L, then responds with `o_ack`=1, `o_err`=1, `o_data`=0.
- Memory read: `o_data` is registered from the array at the edge that asserts `o_ack`.
- Preload writes: one per cycle, at any time. A write at that same edge is not visible in `o_data` (old data returned). Out-of-range or misaligned writes are ignored.
- Reset:
  - Outputs: `o_ack`=0, `o_err`=0, `o_data`=0, `o_busy`=0, `o_overrun`=0.
  - State: FSM=IDLE, pending cleared, LFSR=seed.
  - Memory contents are retained.
  - Reset mid-operation drops in-flight and pending requests with no ack.

## Timing
- Strobe sampled in cycle c → `o_ack` high in cycle c+L. `o_data` and `o_err` are valid in that same cycle.
- `o_busy`=1 from cycle c+1 through c+L inclusive.
- Back-to-back: a request accepted in RESP cycle r acks at r+L'. Peak throughput is one response per `MIN_LAT` cycles.
- `o_ack` is never high in two consecutive cycles unless L=1 and a request is accepted in each RESP cycle.
- Strobes held high across many cycles count as repeated requests. Callers pulse `i_stb` once per fetch.

## Test plan
- Fixed latency: `RANDOM_LAT`=0, `MIN_LAT`=3. Preload word 4 = 32'h0010_0093. Strobe `i_addr`=0x10 in cycle 10 → `o_ack`=1 only in cycle 13, `o_data`=32'h0010_0093, `o_err`=0.
- Misaligned/out of range: strobe `i_addr`=0x12, then `i_addr`=0x1000 with `DEPTH_WORDS`=1024 → each gets `o_ack`=1, `o_err`=1, `o_data`=0.
- Random latency: default seed, 200 sequential fetches from 0x0. Every ack latency is in [1,8], all 8 values occur, and data matches the preload.
- Pending and overrun: `MIN_LAT`=4 fixed. Strobes in cycles 0, 1, 2 → acks in cycles 4 and 8, `o_overrun` high in cycle 3, and the third fetch is never acked.
- Reset mid-flight: `rst` in cycle c+1 of an L=5 request → no ack, all outputs 0 the next cycle. A new fetch after reset returns correct data, and the preloaded contents are intact.
- Write/read collision: a preload write to word 4 in the ack cycle of a word-4 read → the old value is returned, and the next read returns the new value.

Source files
------------

// File: rtl/instr_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : instr_mem_responder
// Brief   : Instruction-memory responder for the fetch strobe/ack interface,
//           with fixed or LFSR-randomised latency and error flagging.
// Rev     : 1.0  initial release
// ============================================================================
module instr_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MIN_LAT     = 1,
    parameter int          MAX_LAT     = 8,
    parameter int          RANDOM_LAT  = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_stb,
    output logic [31:0] o_data,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_busy,
    output logic        o_overrun,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_addr,
    input  logic [31:0] i_wr_data
);

    localparam int          c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [15:0] c_SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] c_MASK     = 16'hB400;
    localparam logic [7:0]  c_LAT_SPAN = 8'(MAX_LAT - MIN_LAT + 1);
    localparam logic [4:0]  c_MIN_LAT  = 5'(MIN_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [4:0]      r_cnt;
    logic [4:0]      w_cnt_n;
    logic            r_pend_v;
    logic            w_pend_v_n;
    logic [31:0]     r_pend_addr;
    logic [31:0]     w_pend_addr_n;
    logic [c_AW-1:0] r_cur_idx;
    logic [c_AW-1:0] w_cur_idx_n;
    logic            r_cur_err;
    logic            w_cur_err_n;
    logic [15:0]     r_lfsr;
    logic            w_acc;
    logic [31:0]     w_acc_addr;
    logic            w_ovr_n;
    logic [4:0]      w_lat;
    logic [29:0]     w_acc_woff;
    logic            w_acc_err;
    logic [c_AW-1:0] w_acc_idx;
    logic [29:0]     w_wr_woff;
    logic            w_wr_ok;

    logic [31:0]     r_mem [DEPTH_WORDS];

    // Word offsets from the base; anything above the array (including
    // addresses below BASE_ADDR, which wrap) is out of range.
    assign w_acc_woff = w_acc_addr[31:2] - BASE_ADDR[31:2];
    assign w_acc_err  = (w_acc_addr[1:0] != 2'b00) || (w_acc_woff[29:c_AW] != '0);
    assign w_acc_idx  = w_acc_woff[c_AW-1:0];

    assign w_wr_woff  = i_wr_addr[31:2] - BASE_ADDR[31:2];
    assign w_wr_ok    = (i_wr_addr[1:0] == 2'b00) && (w_wr_woff[29:c_AW] == '0);

    assign w_lat = (RANDOM_LAT != 0) ? (c_MIN_LAT + 5'(r_lfsr[7:0] % c_LAT_SPAN))
                                     : c_MIN_LAT;

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_pend_v_n    = r_pend_v;
        w_pend_addr_n = r_pend_addr;
        w_cur_idx_n   = r_cur_idx;
        w_cur_err_n   = r_cur_err;
        w_acc         = 1'b0;
        w_acc_addr    = i_addr;
        w_ovr_n       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_stb) begin
                    w_acc = 1'b1;
                end
            end
            S_WAIT: begin
                w_cnt_n = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_state_n = S_RESP;
                end
                if (i_stb) begin
                    if (!r_pend_v) begin
                        w_pend_v_n    = 1'b1;
                        w_pend_addr_n = i_addr;
                    end else begin
                        w_ovr_n = 1'b1;
                    end
                end
            end
            S_RESP: begin
                // The pending request goes first; a concurrent strobe refills the slot.
                if (r_pend_v) begin
                    w_acc         = 1'b1;
                    w_acc_addr    = r_pend_addr;
                    w_pend_v_n    = i_stb;
                    w_pend_addr_n = i_addr;
                end else if (i_stb) begin
                    w_acc = 1'b1;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        if (w_acc) begin
            w_cur_idx_n = w_acc_idx;
            w_cur_err_n = w_acc_err;
            if (w_lat == 5'd1) begin
                w_state_n = S_RESP;
            end else begin
                w_state_n = S_WAIT;
                w_cnt_n   = w_lat - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'd0;
            r_cur_idx   <= '0;
            r_cur_err   <= 1'b0;
            r_lfsr      <= c_SEED;
            o_ack       <= 1'b0;
            o_err       <= 1'b0;
            o_data      <= 32'd0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_pend_v    <= w_pend_v_n;
            r_pend_addr <= w_pend_addr_n;
            r_cur_idx   <= w_cur_idx_n;
            r_cur_err   <= w_cur_err_n;
            r_lfsr      <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_MASK : 16'h0000);
            o_ack       <= (w_state_n == S_RESP);
            o_busy      <= (w_state_n != S_IDLE);
            o_overrun   <= w_ovr_n;
            if (w_state_n == S_RESP) begin
                o_err  <= w_cur_err_n;
                o_data <= w_cur_err_n ? 32'd0 : r_mem[w_cur_idx_n];
            end else begin
                o_err  <= 1'b0;
                o_data <= 32'd0;
            end
        end
    end

    // Contents survive reset; a same-edge read still sees the old word.
    always_ff @(posedge clk) begin
        if (i_wr_en && w_wr_ok) begin
            r_mem[w_wr_woff[c_AW-1:0]] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_instr_mem_responder
// Brief   : Self-checking bench for instr_mem_responder (fixed, random and
//           pending/overrun configurations side by side).
// Rev     : 1.0  initial release
// ============================================================================
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb     [3];
    logic [31:0] addr    [3];
    logic        wr_en   [3];
    logic [31:0] wr_addr [3];
    logic [31:0] wr_data [3];
    logic [31:0] data    [3];
    logic        ack     [3];
    logic        err     [3];
    logic        busy    [3];
    logic        ovr     [3];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_mem [3][1024];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    // Index 0: fixed latency 3; index 1: default random; index 2: fixed latency 4
    instr_mem_responder #(.RANDOM_LAT(0), .MIN_LAT(3), .MAX_LAT(3)) u_fix (
        .clk(clk), .rst(rst), .i_addr(addr[0]), .i_stb(stb[0]),
        .o_data(data[0]), .o_ack(ack[0]), .o_err(err[0]), .o_busy(busy[0]),
        .o_overrun(ovr[0]), .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr[0]),
        .i_wr_data(wr_data[0])
    );

    instr_mem_responder u_rnd (
        .clk(clk), .rst(rst), .i_addr(addr[1]), .i_stb(stb[1]),
        .o_data(data[1]), .o_ack(ack[1]), .o_err(err[1]), .o_busy(busy[1]),
        .o_overrun(ovr[1]), .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1]),
        .i_wr_data(wr_data[1])
    );

    instr_mem_responder #(.RANDOM_LAT(0), .MIN_LAT(4), .MAX_LAT(4)) u_pnd (
        .clk(clk), .rst(rst), .i_addr(addr[2]), .i_stb(stb[2]),
        .o_data(data[2]), .o_ack(ack[2]), .o_err(err[2]), .o_busy(busy[2]),
        .o_overrun(ovr[2]), .i_wr_en(wr_en[2]), .i_wr_addr(wr_addr[2]),
        .i_wr_data(wr_data[2])
    );

    // Reference LFSR: free-running 16-bit Galois, mask B400, seed ACE1
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input int d, input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        wr_en[d] = 1'b1; wr_addr[d] = a; wr_data[d] = v;
        @(negedge clk);
        wr_en[d] = 1'b0;
        if (a[1:0] == 2'b00 && a < 32'd4096) m_mem[d][a[11:2]] = v;
    endtask

    // Latency counts cycles from the strobe cycle to the ack cycle.
    task automatic fetch(input int d, input logic [31:0] a, output int lat,
                         output logic [31:0] rdata, output logic rerr,
                         output logic busy1, output logic [15:0] lf);
        @(negedge clk);
        stb[d] = 1'b1; addr[d] = a; lf = m_lfsr;
        @(negedge clk);
        stb[d] = 1'b0; busy1 = busy[d];
        lat = 1;
        while (!ack[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rdata = data[d];
        rerr  = err[d];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          hist [8];
        int          distinct;
        int          acks;
        int          w;
        logic [31:0] rd;
        logic        re;
        logic        b1;
        logic [15:0] lf;
        logic [31:0] old_v;
        logic        rec_ack [23];
        logic        rec_ovr [23];
        logic [31:0] rec_dat [23];

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            stb[d] = 1'b0; addr[d] = 32'd0;
            wr_en[d] = 1'b0; wr_addr[d] = 32'd0; wr_data[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ack%0d", d),  {31'd0, ack[d]},  32'd0);
            check($sformatf("rst_err%0d", d),  {31'd0, err[d]},  32'd0);
            check($sformatf("rst_data%0d", d), data[d],          32'd0);
            check($sformatf("rst_busy%0d", d), {31'd0, busy[d]}, 32'd0);
            check($sformatf("rst_ovr%0d", d),  {31'd0, ovr[d]},  32'd0);
        end
        rst = 1'b0;

        preload(0, 32'h10, 32'h0010_0093);
        preload(0, 32'h20, 32'h1234_5678);
        preload(0, 32'h22, 32'hDEAD_BEEF);
        for (int i = 0; i < 200; i++) preload(1, i * 4, $urandom);
        for (int i = 0; i < 3; i++) preload(2, i * 4, $urandom);

        // Fixed latency, normal and error fetches
        fetch(0, 32'h10, lat, rd, re, b1, lf);
        check("fix_lat", lat, 3);
        check("fix_data", rd, 32'h0010_0093);
        check("fix_err", {31'd0, re}, 32'd0);
        check("fix_busy", {31'd0, b1}, 32'd1);
        @(negedge clk);
        check("fix_ack_single", {31'd0, ack[0]}, 32'd0);
        check("fix_busy_off", {31'd0, busy[0]}, 32'd0);

        fetch(0, 32'h12, lat, rd, re, b1, lf);
        check("misal_lat", lat, 3);
        check("misal_err", {31'd0, re}, 32'd1);
        check("misal_data", rd, 32'd0);
        fetch(0, 32'h1000, lat, rd, re, b1, lf);
        check("oor_lat", lat, 3);
        check("oor_err", {31'd0, re}, 32'd1);
        check("oor_data", rd, 32'd0);
        fetch(0, 32'h20, lat, rd, re, b1, lf);
        check("misal_wr_ignored", rd, m_mem[0][8]);

        // Random latency sweep
        for (int i = 0; i < 8; i++) hist[i] = 0;
        for (int i = 0; i < 200; i++) begin
            fetch(1, i * 4, lat, rd, re, b1, lf);
            check($sformatf("rnd_lat%0d", i), lat, 32'(1 + (lf[7:0] % 8)));
            check($sformatf("rnd_data%0d", i), rd, m_mem[1][i]);
            check($sformatf("rnd_err%0d", i), {31'd0, re}, 32'd0);
            if (lat >= 1 && lat <= 8) hist[lat-1]++;
        end
        distinct = 0;
        for (int i = 0; i < 8; i++) if (hist[i] > 0) distinct++;
        check("rnd_all_latencies", distinct, 8);

        // Pending slot and overrun: strobes in cycles 0,1,2
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            rec_ack[k] = ack[2]; rec_ovr[k] = ovr[2]; rec_dat[k] = data[2];
            stb[2] = (k < 3); addr[2] = 32'(k * 4);
        end
        stb[2] = 1'b0;
        for (int k = 0; k < 23; k++) begin
            check($sformatf("pnd_ack_c%0d", k), {31'd0, rec_ack[k]}, {31'd0, (k == 4 || k == 8)});
            check($sformatf("pnd_ovr_c%0d", k), {31'd0, rec_ovr[k]}, {31'd0, (k == 3)});
        end
        check("pnd_data0", rec_dat[4], m_mem[2][0]);
        check("pnd_data1", rec_dat[8], m_mem[2][1]);

        // Reset during an L=5 request
        w = 0;
        @(negedge clk);
        while ((1 + (m_lfsr[7:0] % 8)) != 5 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("rst_find_l5", {31'd0, (w < 300)}, 32'd1);
        stb[1] = 1'b1; addr[1] = 32'h40;
        @(negedge clk);
        stb[1] = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ack",  {31'd0, ack[1]},  32'd0);
        check("mid_rst_err",  {31'd0, err[1]},  32'd0);
        check("mid_rst_data", data[1],          32'd0);
        check("mid_rst_busy", {31'd0, busy[1]}, 32'd0);
        check("mid_rst_ovr",  {31'd0, ovr[1]},  32'd0);
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack[1]) acks++;
        end
        check("mid_rst_no_ack", acks, 0);
        fetch(1, 32'h40, lat, rd, re, b1, lf);
        check("post_rst_lat", lat, 32'(1 + (lf[7:0] % 8)));
        check("post_rst_data", rd, m_mem[1][16]);

        // Write to the word being read, at the edge that raises the ack
        old_v = m_mem[0][4];
        @(negedge clk);
        stb[0] = 1'b1; addr[0] = 32'h10;
        @(negedge clk);
        stb[0] = 1'b0;
        @(negedge clk);
        wr_en[0] = 1'b1; wr_addr[0] = 32'h10; wr_data[0] = 32'hCAFE_F00D;
        @(negedge clk);
        wr_en[0] = 1'b0;
        check("coll_ack", {31'd0, ack[0]}, 32'd1);
        check("coll_old_data", data[0], old_v);
        m_mem[0][4] = 32'hCAFE_F00D;
        fetch(0, 32'h10, lat, rd, re, b1, lf);
        check("coll_new_data", rd, m_mem[0][4]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
